// File: rtl/ysyx_23060025_lsu_stage_pkg.sv
// rtl/ysyx_23060025_lsu_stage_pkg.sv - shared encodings, bus widths and FSM states of the LSU stage
//
// Purpose : load/store type encodings, side-bus field layout, stage bus widths,
//           LSU state codes and the misalignment rule used by the stage.
// Ports   : none (package).

package ysyx_23060025_lsu_stage_pkg;

  // Side bus {pc[32], wd[1], wreg[5], csr_wdata[32], csr_waddr[12], csr_type[3], ebreak[1]}
  localparam int ES_SIDE_BUS_WD  = 86;
  localparam int LS_TO_WB_BUS_WD = ES_SIDE_BUS_WD + 32 + 1;
  localparam int LS_TO_DS_FWD_WD = 39;
  localparam int SIDE_WD_BIT     = 53;
  localparam int SIDE_WREG_LSB   = 48;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LW   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_REQ  = 2'd1,
    LS_WAIT = 2'd2,
    LS_DONE = 2'd3
  } ls_state_e;

  // Halfword accesses need an even address, word accesses a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] load_type,
                                         input logic [1:0] store_type,
                                         input logic [1:0] addr_lo);
    logic half;
    logic word;
    half = (load_type == LD_LH) || (load_type == LD_LHU) || (store_type == ST_SH);
    word = (load_type == LD_LW) || (store_type == ST_SW);
    return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060025_lsu_align.sv
// rtl/ysyx_23060025_lsu_align.sv - byte-lane alignment for stores and loads
//
// Purpose : combinational lane steering between the 32-bit data bus and the core.
// Ports   : addr_lo    - low two bits of the byte address
//           load_type  - load encoding (0 = none)
//           store_type - store encoding (0 = none)
//           store_data - store source register value
//           rdata      - raw word returned by the data bus
//           wstrb      - byte enables for the store
//           wdata      - store data replicated across lanes
//           load_data  - extracted and extended load result

module ysyx_23060025_lsu_align
  import ysyx_23060025_lsu_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    wstrb = 4'b0000;
    wdata = store_data;
    case (store_type)
      ST_SB: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      ST_SH: begin
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      ST_SW: wstrb = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = 32'h0;
    case (load_type)
      LD_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      LD_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      LD_LW:   load_data = rdata;
      LD_LBU:  load_data = {24'h0, lane_byte};
      LD_LHU:  load_data = {16'h0, lane_half};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060025_lsu_stage.sv
// rtl/ysyx_23060025_lsu_stage.sv - load/store pipeline stage with a request/grant/response data bus
//
// Purpose : accepts one instruction from EX, performs at most one data-bus access for it,
//           and hands the result to WB; non-memory ops pass through in one cycle.
// Ports   : clock, reset (async, active low)
//           es_to_lsu_valid_i / lsu_allowin_o       - upstream handshake
//           alu_result_i, mem_wdata_i, load_type_i,
//           store_type_i, es_side_bus_i              - EX payload, latched on accept
//           mem_req_o/we/addr/wdata/wstrb            - data-bus request (word-aligned address)
//           mem_gnt_i/rvalid_i/err_i/rdata_i         - data-bus grant and response
//           ls_to_wb_valid_o / wb_allowin_i          - downstream handshake
//           ls_to_wb_bus_o                           - {side bus, wb_data, access_err}
//           ls_to_ds_forward_bus_o                   - {dep_need_stall, forward_enable, wreg, wb_data}

module ysyx_23060025_lsu_stage
  import ysyx_23060025_lsu_stage_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       es_to_lsu_valid_i,
  output logic                       lsu_allowin_o,
  input  logic [DATA_LEN-1:0]        alu_result_i,
  input  logic [DATA_LEN-1:0]        mem_wdata_i,
  input  logic [2:0]                 load_type_i,
  input  logic [1:0]                 store_type_i,
  input  logic [ES_SIDE_BUS_WD-1:0]  es_side_bus_i,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [31:0]                mem_addr_o,
  output logic [31:0]                mem_wdata_o,
  output logic [3:0]                 mem_wstrb_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic                       mem_err_i,
  input  logic [31:0]                mem_rdata_i,
  output logic                       ls_to_wb_valid_o,
  input  logic                       wb_allowin_i,
  output logic [LS_TO_WB_BUS_WD-1:0] ls_to_wb_bus_o,
  output logic [LS_TO_DS_FWD_WD-1:0] ls_to_ds_forward_bus_o
);

  ls_state_e                 state;
  ls_state_e                 state_next;
  logic                      ls_valid;
  logic [DATA_LEN-1:0]       ls_alu;
  logic [DATA_LEN-1:0]       ls_wdata;
  logic [2:0]                ls_load_type;
  logic [1:0]                ls_store_type;
  logic [ES_SIDE_BUS_WD-1:0] ls_side;
  logic                      access_err;
  logic [31:0]               ld_data;

  logic        accept;
  logic        in_is_mem;
  logic        in_misaligned;
  logic        ls_is_load;
  logic        ls_is_store;
  logic        ls_ready_go;
  logic [31:0] wb_data;
  logic [3:0]  align_wstrb;
  logic [31:0] align_wdata;
  logic [31:0] align_load_data;
  logic        forward_enable;
  logic        dep_need_stall;

  assign in_is_mem     = (load_type_i != LD_NONE) || (store_type_i != ST_NONE);
  assign in_misaligned = in_is_mem && is_misaligned(load_type_i, store_type_i, alu_result_i[1:0]);
  assign ls_is_load    = (ls_load_type != LD_NONE);
  assign ls_is_store   = (ls_store_type != ST_NONE);

  // Memory ops are only ready once their response (or misalignment) has landed in DONE.
  assign ls_ready_go   = (ls_is_load || ls_is_store) ? (state == LS_DONE) : 1'b1;
  assign lsu_allowin_o = !ls_valid || (ls_ready_go && wb_allowin_i);
  assign accept        = es_to_lsu_valid_i && lsu_allowin_o;

  ysyx_23060025_lsu_align u_align (
    .addr_lo    (ls_alu[1:0]),
    .load_type  (ls_load_type),
    .store_type (ls_store_type),
    .store_data (ls_wdata[31:0]),
    .rdata      (mem_rdata_i),
    .wstrb      (align_wstrb),
    .wdata      (align_wdata),
    .load_data  (align_load_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      LS_IDLE: state_next = LS_IDLE;
      LS_REQ:  if (mem_gnt_i) state_next = LS_WAIT;
      LS_WAIT: if (mem_rvalid_i) state_next = LS_DONE;
      LS_DONE: if (ls_ready_go && wb_allowin_i) state_next = LS_IDLE;
      default: state_next = LS_IDLE;
    endcase
    // An accept only happens from IDLE or while DONE is retiring, so it overrides.
    if (accept && in_is_mem) begin
      state_next = in_misaligned ? LS_DONE : LS_REQ;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= LS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ls_valid      <= 1'b0;
      ls_alu        <= '0;
      ls_wdata      <= '0;
      ls_load_type  <= LD_NONE;
      ls_store_type <= ST_NONE;
      ls_side       <= '0;
      access_err    <= 1'b0;
      ld_data       <= 32'h0;
    end else begin
      if (lsu_allowin_o) begin
        ls_valid <= es_to_lsu_valid_i;
      end
      if (accept) begin
        ls_alu        <= alu_result_i;
        ls_wdata      <= mem_wdata_i;
        ls_load_type  <= load_type_i;
        ls_store_type <= store_type_i;
        ls_side       <= es_side_bus_i;
        access_err    <= in_misaligned;
        ld_data       <= 32'h0;
      end else if ((state == LS_WAIT) && mem_rvalid_i) begin
        access_err <= mem_err_i;
        ld_data    <= mem_err_i ? 32'h0 : align_load_data;
      end
    end
  end

  // A faulted access (misaligned or bus error) always reports zero data.
  assign wb_data = access_err ? 32'h0 : (ls_is_load ? ld_data : ls_alu[31:0]);

  assign mem_req_o   = (state == LS_REQ);
  assign mem_we_o    = mem_req_o && ls_is_store;
  assign mem_addr_o  = {ls_alu[31:2], 2'b00};
  assign mem_wdata_o = align_wdata;
  assign mem_wstrb_o = (mem_req_o && ls_is_store) ? align_wstrb : 4'b0000;

  assign forward_enable = ls_valid && ls_side[SIDE_WD_BIT] &&
                          (ls_side[SIDE_WREG_LSB +: 5] != 5'd0);
  assign dep_need_stall = ls_valid && ls_is_load && !ls_ready_go;

  assign ls_to_wb_valid_o       = ls_valid && ls_ready_go;
  assign ls_to_wb_bus_o         = {ls_side, wb_data, access_err};
  assign ls_to_ds_forward_bus_o = {dep_need_stall, forward_enable,
                                   ls_side[SIDE_WREG_LSB +: 5], wb_data};

endmodule
